// File: rtl/bnn_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module  : bnn_stream_feeder
// Brief   : Host-loaded image/weight buffer that streams into the BNN core and
//           returns its class result over a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module bnn_stream_feeder #(
  parameter int IMG_BITS     = 784,
  parameter int CONV_TAPS    = 9,
  parameter int CONV_KERNELS = 2,
  parameter int FC_DEPTH     = 288
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [9:0] cfg_addr,
  input  logic [9:0] cfg_wdata,
  input  logic       run,
  input  logic       res_ready,
  output logic       res_valid,
  output logic [3:0] res_class,
  output logic       busy,
  output logic       err,
  output logic       start,
  output logic       image_in,
  output logic       weight_conv_in,
  output logic [9:0] weight_fc_in,
  input  logic       weight_en_0,
  input  logic       weight_en_1,
  input  logic       fc_ivalid,
  input  logic       done,
  input  logic [3:0] classes_b
);

  localparam int CONV_BITS = CONV_TAPS * CONV_KERNELS;
  localparam int IMG_AW    = $clog2(IMG_BITS);
  localparam int IMG_PW    = $clog2(IMG_BITS + 1);
  localparam int CONV_AW   = $clog2(CONV_BITS);
  localparam int TAP_W     = $clog2(CONV_TAPS);
  localparam int FC_AW     = $clog2(FC_DEPTH);
  localparam int FC_PW     = $clog2(FC_DEPTH + 1);

  localparam logic [IMG_PW-1:0] c_IMG_END  = IMG_PW'(IMG_BITS);
  localparam logic [FC_PW-1:0]  c_FC_END   = FC_PW'(FC_DEPTH);
  localparam logic [TAP_W-1:0]  c_TAP_LAST = TAP_W'(CONV_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STREAM    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESULT    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_img_mem  [IMG_BITS];
  logic              r_conv_mem [CONV_BITS];
  logic [9:0]        r_fc_mem   [FC_DEPTH];

  logic [IMG_PW-1:0] r_img_ptr;
  logic [TAP_W-1:0]  r_p0;
  logic [TAP_W-1:0]  r_p1;
  logic [FC_PW-1:0]  r_fc_ptr;

  logic              r_res_valid;
  logic [3:0]        r_res_class;
  logic              r_busy;
  logic              r_err;
  logic              r_start;
  logic              r_image_in;
  logic              r_conv_out;
  logic [9:0]        r_fc_out;

  logic              w_addr_ok;
  logic              w_wr_idle;
  logic [CONV_AW-1:0] w_k0_idx;
  logic [CONV_AW-1:0] w_k1_idx;

  // Reserved target (sel 3) counts as in-range so it is silently ignored.
  always_comb begin
    w_addr_ok = 1'b1;
    case (cfg_sel)
      2'd0:    w_addr_ok = (cfg_addr < 10'(IMG_BITS));
      2'd1:    w_addr_ok = (cfg_addr < 10'(CONV_BITS));
      2'd2:    w_addr_ok = (cfg_addr < 10'(FC_DEPTH));
      default: w_addr_ok = 1'b1;
    endcase
  end

  assign w_wr_idle = rstn && (r_state == S_IDLE) && cfg_we && w_addr_ok;
  assign w_k0_idx  = CONV_AW'(r_p0);
  assign w_k1_idx  = CONV_AW'(CONV_TAPS) + CONV_AW'(r_p1);

  always_ff @(posedge clk) begin
    if (w_wr_idle && (cfg_sel == 2'd0)) r_img_mem[cfg_addr[IMG_AW-1:0]]   <= cfg_wdata[0];
    if (w_wr_idle && (cfg_sel == 2'd1)) r_conv_mem[cfg_addr[CONV_AW-1:0]] <= cfg_wdata[0];
    if (w_wr_idle && (cfg_sel == 2'd2)) r_fc_mem[cfg_addr[FC_AW-1:0]]     <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_img_ptr   <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_fc_ptr    <= '0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_image_in  <= 1'b0;
      r_conv_out  <= 1'b0;
      r_fc_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we && !w_addr_ok) r_err <= 1'b1;
          if (run) begin
            r_img_ptr <= '0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_fc_ptr  <= '0;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM, S_WAIT_DONE: begin
          if (cfg_we) r_err <= 1'b1;
          if (done) begin
            r_res_class <= classes_b;
            r_res_valid <= 1'b1;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_image_in  <= 1'b0;
            r_conv_out  <= 1'b0;
            r_fc_out    <= '0;
            r_state     <= S_RESULT;
          end else begin
            if (r_state == S_STREAM) begin
              if (r_img_ptr == c_IMG_END) begin
                r_image_in <= 1'b0;
                r_state    <= S_WAIT_DONE;
              end else begin
                r_image_in <= r_img_mem[r_img_ptr[IMG_AW-1:0]];
                r_img_ptr  <= r_img_ptr + IMG_PW'(1);
              end
            end
            // Kernel 0 wins when both kernels request in the same cycle.
            if (weight_en_0) begin
              r_conv_out <= r_conv_mem[w_k0_idx];
              r_p0       <= (r_p0 == c_TAP_LAST) ? '0 : r_p0 + TAP_W'(1);
            end else if (weight_en_1) begin
              r_conv_out <= r_conv_mem[w_k1_idx];
              r_p1       <= (r_p1 == c_TAP_LAST) ? '0 : r_p1 + TAP_W'(1);
            end
            if (fc_ivalid) begin
              if (r_fc_ptr == c_FC_END) begin
                r_fc_out <= '0;
                r_err    <= 1'b1;
              end else begin
                r_fc_out <= r_fc_mem[r_fc_ptr[FC_AW-1:0]];
                r_fc_ptr <= r_fc_ptr + FC_PW'(1);
              end
            end
          end
        end
        S_RESULT: begin
          if (cfg_we) r_err <= 1'b1;
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid      = r_res_valid;
  assign res_class      = r_res_class;
  assign busy           = r_busy;
  assign err            = r_err;
  assign start          = r_start;
  assign image_in       = r_image_in;
  assign weight_conv_in = r_conv_out;
  assign weight_fc_in   = r_fc_out;

endmodule
`default_nettype wire
